// File: rtl/tft_line_buffer.sv
// ---------------------------------------------------------------------------
// tft_line_buffer : ping-pong RGB565 line buffer feeding a TFT timing ctrl.
// Optional: TFT_LINEBUF_UFCNT_EN adds a saturating underrun counter output.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tft_line_buffer #(
  parameter int          H_ACTIVE        = 480,
  parameter int          V_ACTIVE        = 272,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic        Clk9M,
  input  logic        Rst_n,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] data_out,
  input  logic        clr_underflow,
  output logic        underflow
`ifdef TFT_LINEBUF_UFCNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int               PTR_W    = $clog2(H_ACTIVE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(H_ACTIVE - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);

  logic [15:0] mem [2][H_ACTIVE];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             rd_bank_q, rd_bank_d;
  logic             line_ok_q, line_ok_d;
  logic             line_armed_q, line_armed_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             underflow_q, underflow_d;

  logic             wr_fire, wr_last, v_active, line_start, pix_read, line_end, uf_set;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic [15:0]      rd_word;

  assign s_ready   = !full_q[wr_bank_q];
  assign data_out  = data_out_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_fire    = s_valid && s_ready;
    wr_idx     = s_sof ? '0 : wr_ptr_q;
    wr_last    = (wr_idx == PTR_LAST);
    v_active   = (vcount < V_LIM);
    line_start = (hcount == 10'h3FF) && v_active;
    pix_read   = (hcount < H_LAST) && v_active;
    line_end   = (hcount == H_LAST) && v_active && line_ok_q;
    // Read one pixel ahead so the registered output lines up with hcount.
    rd_idx     = line_start ? '0 : hcount[PTR_W-1:0] + PTR_W'(1);
    rd_word    = mem[rd_bank_q][rd_idx];
    uf_set     = line_start && !full_q[rd_bank_q];

    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    wr_ptr_d     = wr_ptr_q;
    rd_bank_d    = rd_bank_q;
    line_ok_d    = line_ok_q;
    line_armed_d = line_armed_q;
    data_out_d   = 16'h0000;

    if (wr_fire) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_idx + PTR_W'(1);
      end
    end

    // An underrun line never reaches line_end, so its bank is retried next line.
    if (line_end) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    // line_armed keeps the output at zero after a mid-line reset until a line start.
    if (line_start) begin
      line_armed_d = 1'b1;
      if (full_q[rd_bank_q]) begin
        line_ok_d  = 1'b1;
        data_out_d = rd_word;
      end else begin
        line_ok_d  = 1'b0;
        data_out_d = UNDERFLOW_COLOR;
      end
    end else if (pix_read && line_armed_q) begin
      data_out_d = line_ok_q ? rd_word : UNDERFLOW_COLOR;
    end

    underflow_d = uf_set ? 1'b1 : (clr_underflow ? 1'b0 : underflow_q);
  end

  always_ff @(posedge Clk9M) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_idx] <= s_data;
    end
  end

  always_ff @(posedge Clk9M or negedge Rst_n) begin
    if (!Rst_n) begin
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_bank_q    <= 1'b0;
      line_ok_q    <= 1'b0;
      line_armed_q <= 1'b0;
      data_out_q   <= 16'h0000;
      underflow_q  <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_bank_q    <= rd_bank_d;
      line_ok_q    <= line_ok_d;
      line_armed_q <= line_armed_d;
      data_out_q   <= data_out_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef TFT_LINEBUF_UFCNT_EN
  logic [15:0] ufcnt_q, ufcnt_d;

  // A new underrun beats a simultaneous clear; the result is then 1.
  always_comb begin
    ufcnt_d = ufcnt_q;
    if (uf_set) begin
      if (clr_underflow) begin
        ufcnt_d = 16'd1;
      end else if (ufcnt_q != 16'hFFFF) begin
        ufcnt_d = ufcnt_q + 16'd1;
      end
    end else if (clr_underflow) begin
      ufcnt_d = 16'd0;
    end
  end

  always_ff @(posedge Clk9M or negedge Rst_n) begin
    if (!Rst_n) begin
      ufcnt_q <= 16'd0;
    end else begin
      ufcnt_q <= ufcnt_d;
    end
  end

  assign underflow_cnt = ufcnt_q;
`endif

endmodule

`default_nettype wire
